// File: rtl/system_reset_sequencer.sv
// Power-on reset sequencer: qualifies PLL lock, waits a settle delay, then releases
// downstream reset domains one at a time, each gated by the previous domain's ready.
module system_reset_sequencer #(
    parameter int          NUM_STAGES  = 3,
    parameter logic [15:0] LOCK_FILTER = 16'd1000,
    parameter logic [23:0] INIT_DELAY  = 24'd2500000,
    parameter logic [23:0] STAGE_GAP   = 24'd50000,
    parameter logic [23:0] ACK_TIMEOUT = 24'd5000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  sys_ready,
    output logic                  seq_fault,
    output logic [2:0]            fault_stage,
    output logic [2:0]            seq_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT_WAIT = 3'd1,
        WAIT_ACK  = 3'd2,
        GAP       = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [23:0]           cyc_cnt_r, cyc_cnt_s;
    logic [15:0]           lock_cnt_r, lock_cnt_s;
    logic [2:0]            idx_r, idx_s, idx_inc_s;
    logic [NUM_STAGES-1:0] stage_rst_n_r, stage_rst_n_s;
    logic                  sys_ready_r, sys_ready_s;
    logic                  seq_fault_r, seq_fault_s;
    logic [2:0]            fault_stage_r, fault_stage_s;
    logic                  ready_sel_s;
    logic                  restart_s;

    // State, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cyc_cnt_r     <= 24'd0;
            lock_cnt_r    <= 16'd0;
            idx_r         <= 3'd0;
            stage_rst_n_r <= {NUM_STAGES{1'b0}};
            sys_ready_r   <= 1'b0;
            seq_fault_r   <= 1'b0;
            fault_stage_r <= 3'd0;
        end else begin
            state_r       <= state_nxt_s;
            cyc_cnt_r     <= cyc_cnt_s;
            lock_cnt_r    <= lock_cnt_s;
            idx_r         <= idx_s;
            stage_rst_n_r <= stage_rst_n_s;
            sys_ready_r   <= sys_ready_s;
            seq_fault_r   <= seq_fault_s;
            fault_stage_r <= fault_stage_s;
        end
    end

    // Next-state selection; lock loss and soft reset override everything except FAULT
    always_comb begin
        state_nxt_s = state_r;
        ready_sel_s = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_r == 3'(i)) begin
                ready_sel_s = stage_ready[i];
            end else begin
                ready_sel_s = ready_sel_s;
            end
        end
        restart_s = (state_r != FAULT) && (!pll_locked || soft_rst_req);

        case (state_r)
            IDLE: begin
                if (!restart_s && (lock_cnt_r == LOCK_FILTER - 16'd1)) begin
                    state_nxt_s = INIT_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            INIT_WAIT: begin
                if (restart_s) begin
                    state_nxt_s = IDLE;
                end else if (cyc_cnt_r == INIT_DELAY - 24'd1) begin
                    state_nxt_s = WAIT_ACK;
                end else begin
                    state_nxt_s = INIT_WAIT;
                end
            end
            WAIT_ACK: begin
                if (restart_s) begin
                    state_nxt_s = IDLE;
                end else if (ready_sel_s) begin
                    state_nxt_s = (idx_r == 3'(NUM_STAGES - 1)) ? RUN : GAP;
                end else if (cyc_cnt_r == ACK_TIMEOUT - 24'd1) begin
                    state_nxt_s = FAULT;
                end else begin
                    state_nxt_s = WAIT_ACK;
                end
            end
            GAP: begin
                if (restart_s) begin
                    state_nxt_s = IDLE;
                end else if (cyc_cnt_r == STAGE_GAP - 24'd1) begin
                    state_nxt_s = WAIT_ACK;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            RUN: begin
                if (restart_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FAULT: begin
                if (soft_rst_req) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FAULT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Counter and output updates derived from the chosen transition
    always_comb begin
        idx_s         = idx_r;
        idx_inc_s     = idx_r + 3'd1;
        stage_rst_n_s = stage_rst_n_r;
        sys_ready_s   = sys_ready_r;
        seq_fault_s   = seq_fault_r;
        fault_stage_s = fault_stage_r;

        if (state_nxt_s != state_r) begin
            cyc_cnt_s = 24'd0;
        end else if ((state_r == INIT_WAIT) || (state_r == WAIT_ACK) || (state_r == GAP)) begin
            cyc_cnt_s = cyc_cnt_r + 24'd1;
        end else begin
            cyc_cnt_s = 24'd0;
        end

        if ((state_r == IDLE) && (state_nxt_s == IDLE) && pll_locked && !soft_rst_req) begin
            lock_cnt_s = lock_cnt_r + 16'd1;
        end else begin
            lock_cnt_s = 16'd0;
        end

        if (state_nxt_s == IDLE) begin
            idx_s         = 3'd0;
            stage_rst_n_s = {NUM_STAGES{1'b0}};
            sys_ready_s   = 1'b0;
            if (state_r == FAULT) begin
                seq_fault_s   = 1'b0;
                fault_stage_s = 3'd0;
            end else begin
                seq_fault_s   = seq_fault_r;
                fault_stage_s = fault_stage_r;
            end
        end else begin
            case (state_r)
                INIT_WAIT: begin
                    if (state_nxt_s == WAIT_ACK) begin
                        idx_s            = 3'd0;
                        stage_rst_n_s[0] = 1'b1;
                    end else begin
                        stage_rst_n_s = stage_rst_n_r;
                    end
                end
                WAIT_ACK: begin
                    if (state_nxt_s == RUN) begin
                        sys_ready_s = 1'b1;
                    end else if (state_nxt_s == FAULT) begin
                        seq_fault_s   = 1'b1;
                        fault_stage_s = idx_r;
                        stage_rst_n_s = {NUM_STAGES{1'b0}};
                        sys_ready_s   = 1'b0;
                    end else begin
                        sys_ready_s = sys_ready_r;
                    end
                end
                GAP: begin
                    if (state_nxt_s == WAIT_ACK) begin
                        idx_s = idx_inc_s;
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (idx_inc_s == 3'(i)) begin
                                stage_rst_n_s[i] = 1'b1;
                            end else begin
                                stage_rst_n_s[i] = stage_rst_n_r[i];
                            end
                        end
                    end else begin
                        stage_rst_n_s = stage_rst_n_r;
                    end
                end
                default: stage_rst_n_s = stage_rst_n_r;
            endcase
        end
    end

    assign stage_rst_n = stage_rst_n_r;
    assign sys_ready   = sys_ready_r;
    assign seq_fault   = seq_fault_r;
    assign fault_stage = fault_stage_r;
    assign seq_state   = state_r;

endmodule

// File: tb/tb_system_reset_sequencer.sv
// Scoreboard bench for system_reset_sequencer: a time-stamp based reference model
// predicts every post-edge output; a monitor compares independently of the stimulus.
module tb_system_reset_sequencer;

    localparam int NS    = 3;
    localparam int LF    = 4;
    localparam int ID    = 10;
    localparam int SG    = 3;
    localparam int AT    = 20;
    localparam int NEVER = 100000;

    typedef struct packed {
        logic [2:0] srn;
        logic       rdy;
        logic       flt;
        logic [2:0] fst;
        logic [2:0] st;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          soft_rst_req = 1'b0;
    logic [NS-1:0] stage_ready = '0;
    logic [NS-1:0] stage_rst_n;
    logic          sys_ready;
    logic          seq_fault;
    logic [2:0]    fault_stage;
    logic [2:0]    seq_state;

    int   n_checks = 0;
    int   n_errs = 0;
    exp_t exp_q[$];

    int m_edge = 0, m_mark = 0, m_lock_start = -1, m_nrel = 0, m_fstage = 0, m_phase = 0;
    int age[NS];
    int dly[NS];
    bit rand_mode = 1'b0;

    always #5 clk = ~clk;

    system_reset_sequencer #(
        .NUM_STAGES (NS),
        .LOCK_FILTER(16'd4),
        .INIT_DELAY (24'd10),
        .STAGE_GAP  (24'd3),
        .ACK_TIMEOUT(24'd20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .soft_rst_req(soft_rst_req),
        .stage_ready (stage_ready),
        .stage_rst_n (stage_rst_n),
        .sys_ready   (sys_ready),
        .seq_fault   (seq_fault),
        .fault_stage (fault_stage),
        .seq_state   (seq_state)
    );

    // Reference model: phases are timed by absolute edge stamps, released stages by a count
    task automatic model_reset();
        m_phase = 0; m_nrel = 0; m_lock_start = -1; m_fstage = 0; m_mark = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   v;
        v     = (1 << m_nrel) - 1;
        e.srn = v[2:0];
        e.rdy = (m_phase == 4);
        e.flt = (m_phase == 5);
        e.fst = 3'(m_fstage);
        e.st  = 3'(m_phase);
        return e;
    endfunction

    task automatic model_step();
        m_edge++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_phase != 5 && (!pll_locked || soft_rst_req)) begin
            m_phase = 0; m_nrel = 0; m_lock_start = -1;
            return;
        end
        case (m_phase)
            0: begin
                if (m_lock_start < 0) m_lock_start = m_edge;
                if (m_edge - m_lock_start + 1 == LF) begin m_phase = 1; m_mark = m_edge; end
            end
            1: if (m_edge - m_mark == ID) begin m_phase = 2; m_nrel = 1; m_mark = m_edge; end
            2: begin
                if (stage_ready[m_nrel-1]) begin
                    m_phase = (m_nrel == NS) ? 4 : 3;
                    m_mark  = m_edge;
                end else if (m_edge - m_mark == AT) begin
                    m_phase = 5; m_fstage = m_nrel - 1; m_nrel = 0;
                end
            end
            3: if (m_edge - m_mark == SG) begin m_nrel++; m_phase = 2; m_mark = m_edge; end
            5: if (soft_rst_req) begin m_phase = 0; m_lock_start = -1; m_fstage = 0; end
            default: ;
        endcase
    endtask

    // One clock: model predicts at the edge, then the domain responder updates stage_ready
    task automatic tick();
        @(posedge clk);
        model_step();
        exp_q.push_back(model_out());
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            if (stage_rst_n[i]) begin
                age[i]++;
                if (age[i] == 1 && rand_mode)
                    dly[i] = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 22));
            end else begin
                age[i] = 0;
            end
            stage_ready[i] = (age[i] >= dly[i]) && !(rand_mode && $urandom_range(0, 14) == 0);
        end
    endtask

    task automatic check(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2);
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
    endtask

    task automatic ticks_until_rel(input int b, output int n);
        n = 0;
        while (n < 200 && !stage_rst_n[b]) begin tick(); n++; end
    endtask

    task automatic wait_state(input int s, input string nm, output int n);
        n = 0;
        while (n < 400 && seq_state != 3'(s)) begin tick(); n++; end
        check(nm, int'(seq_state), s);
    endtask

    task automatic async_reset(input int hold);
        #2;
        rst_n = 1'b0;
        model_reset();
        exp_q.push_back(model_out());
        #1;
        check("async_rst_state", int'(seq_state), 0);
        repeat (hold) tick();
        rst_n = 1'b1;
    endtask

    // Monitor: compares every DUT output update against the oldest prediction
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{srn: stage_rst_n, rdy: sys_ready, flt: seq_fault, fst: fault_stage, st: seq_state};
                n_checks++;
                if (a !== e) begin
                    n_errs++;
                    $display("FAIL scoreboard t=%0t: got rst_n=%b rdy=%b flt=%b fst=%0d st=%0d, expected rst_n=%b rdy=%b flt=%b fst=%0d st=%0d",
                             $time, a.srn, a.rdy, a.flt, a.fst, a.st, e.srn, e.rdy, e.flt, e.fst, e.st);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, glitch;
        for (int i = 0; i < NS; i++) begin age[i] = 0; dly[i] = 2; end
        repeat (3) tick();
        rst_n = 1'b1;

        // 1: nominal sequence
        pll_locked = 1'b1;
        ticks_until_rel(0, n);
        check("t1_rel0_edge", n, 14);
        ticks_until_rel(1, n2);
        check("t1_gap_rel1", n2, 5);
        ticks_until_rel(2, n2);
        check("t1_gap_rel2", n2, 5);
        wait_state(4, "t1_run", n);
        check("t1_run_lat", n, 2);
        check("t1_all_released", int'(stage_rst_n), 7);

        // 2: one-cycle lock glitch at edge 3
        pll_locked = 1'b0; tick(); tick();
        pll_locked = 1'b1; tick(); tick();
        pll_locked = 1'b0; tick();
        pll_locked = 1'b1;
        ticks_until_rel(0, n);
        check("t2_rel0_edge", n + 3, 17);

        // 3: stage 1 never ready -> timeout, fault survives lock loss, soft reset clears
        pll_locked = 1'b0; tick();
        set_dly(2, NEVER, 2);
        pll_locked = 1'b1;
        ticks_until_rel(1, n);
        n = 0;
        while (n < 200 && !seq_fault) begin tick(); n++; end
        check("t3_timeout_cycles", n, 20);
        check("t3_fault_stage", int'(fault_stage), 1);
        check("t3_rst_asserted", int'(stage_rst_n), 0);
        pll_locked = 1'b0; repeat (3) tick();
        check("t3_fault_sticky", int'(seq_fault), 1);
        pll_locked = 1'b1; tick();
        soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
        check("t3_fault_cleared", int'(seq_fault), 0);
        set_dly(2, 2, 2);
        wait_state(4, "t3_rerun", n);

        // 4: lock loss in RUN
        pll_locked = 1'b0; tick();
        check("t4_state_idle", int'(seq_state), 0);
        check("t4_sys_ready", int'(sys_ready), 0);
        pll_locked = 1'b1;
        wait_state(4, "t4_rerun", n);

        // 5: soft reset during GAP, then ready coincident with timeout
        pll_locked = 1'b0; tick(); pll_locked = 1'b1;
        wait_state(3, "t5_gap", n);
        soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
        check("t5_rst_asserted", int'(stage_rst_n), 0);
        set_dly(AT, 2, 2);
        wait_state(4, "t5_ready_wins", n);
        check("t5_no_fault", int'(seq_fault), 0);

        // 6: async reset mid-INIT_WAIT (count 5)
        pll_locked = 1'b0; tick(); pll_locked = 1'b1;
        set_dly(2, 2, 2);
        repeat (9) tick();
        async_reset(2);
        ticks_until_rel(0, n);
        check("t6_rel0_edge", n, 14);

        // Randomized traffic against the model
        rand_mode = 1'b1;
        glitch = 0;
        for (int k = 0; k < 3000; k++) begin
            if (glitch > 0) begin
                glitch--; pll_locked = 1'b0;
            end else begin
                pll_locked = 1'b1;
                if ($urandom_range(0, 199) == 0) glitch = $urandom_range(1, 3);
            end
            soft_rst_req = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                soft_rst_req = 1'b0;
                async_reset(2);
            end
            tick();
        end
        soft_rst_req = 1'b0;
        rand_mode = 1'b0;
        repeat (5) tick();

        @(posedge clk); #2;
        check("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
